// File: rtl/alu_multicycle.sv
// -----------------------------------------------------------------------------
// alu_multicycle
//   Execution unit for the multicycle datapath. It takes the 6-bit ALU function
//   code and the 5-bit shift amount from the ALU control decoder, computes the
//   instruction result, and registers it together with the flags.
//
//   Single-cycle ops finish one edge after start. Multiply is an unsigned
//   shift-add engine that runs for WIDTH iterations. The main control FSM uses
//   start/busy/done to stall in its execute state.
//
//   Build option:
//     ALU_FAST_MUL_EN  When defined, mul is a combinational WIDTH x WIDTH
//                      product with single-cycle latency. In that build busy
//                      never asserts and the MUL state does not exist.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     start      operation request; only accepted in IDLE
//     func       ALU function code
//     shift_amt  shift distance (0..31) for sll/srl/sra
//     op_a       operand A (rs)
//     op_b       operand B (rt or sign-extended immediate)
//     busy       multiply in progress
//     done       one-cycle pulse; result and flags valid
//     result     registered result
//     zero       result == 0
//     carry      add carry-out / sub borrow
//     ovf        signed overflow (add/sub); upper product non-zero (mul)
// -----------------------------------------------------------------------------
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [4:0]       shift_amt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             ovf
);

  localparam logic [5:0] F_ADD = 6'd0;
  localparam logic [5:0] F_SUB = 6'd1;
  localparam logic [5:0] F_AND = 6'd2;
  localparam logic [5:0] F_MUL = 6'd3;
  localparam logic [5:0] F_OR  = 6'd4;
  localparam logic [5:0] F_XOR = 6'd5;
  localparam logic [5:0] F_SLL = 6'd6;
  localparam logic [5:0] F_SRL = 6'd7;
  localparam logic [5:0] F_SRA = 6'd8;
  localparam logic [5:0] F_SLT = 6'd9;

  // Result bundle written into the output registers on completion.
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             carry;
    logic             ovf;
  } alu_rsp_t;

`ifdef ALU_FAST_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t   state, state_nxt;
  alu_rsp_t rsp_c;
  logic     accept;

  assign accept = (state == S_IDLE) && start;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  // One extra bit on each side captures carry-out / borrow directly.
  logic [WIDTH:0] sum_w, diff_w;
  assign sum_w  = {1'b0, op_a} + {1'b0, op_b};
  assign diff_w = {1'b0, op_a} - {1'b0, op_b};

`ifdef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod_w;
  assign prod_w = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
`endif

  always_comb begin
    rsp_c = '0;
    unique case (func)
      F_ADD: begin
        rsp_c.res   = sum_w[WIDTH-1:0];
        rsp_c.carry = sum_w[WIDTH];
        // Same-sign operands producing a different-sign sum.
        rsp_c.ovf   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                      (sum_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      F_SUB: begin
        rsp_c.res   = diff_w[WIDTH-1:0];
        rsp_c.carry = diff_w[WIDTH];
        // Opposite-sign operands where the difference takes op_b's sign.
        rsp_c.ovf   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                      (diff_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      F_AND: rsp_c.res = op_a & op_b;
      F_OR:  rsp_c.res = op_a | op_b;
      F_XOR: rsp_c.res = op_a ^ op_b;
      F_SLL: rsp_c.res = op_b << shift_amt;
      F_SRL: rsp_c.res = op_b >> shift_amt;
      F_SRA: rsp_c.res = $signed(op_b) >>> shift_amt;
      F_SLT: rsp_c.res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
`ifdef ALU_FAST_MUL_EN
      F_MUL: begin
        rsp_c.res = prod_w[WIDTH-1:0];
        rsp_c.ovf = |prod_w[2*WIDTH-1:WIDTH];
      end
`else
      // Iterative path owns mul; this branch is never registered.
      F_MUL: rsp_c = '0;
`endif
      default: rsp_c = '0;
    endcase
    rsp_c.zero = (rsp_c.res == '0);
  end

`ifndef ALU_FAST_MUL_EN
  // ---------------------------------------------------------------------------
  // Iterative shift-add multiplier
  // ---------------------------------------------------------------------------
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic               is_mul;
  logic [2*WIDTH-1:0] mcand, acc, acc_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_last;

  assign is_mul   = (func == F_MUL);
  assign mul_last = (state == S_MUL) && (cnt == CNT_LAST);
  // Partial-product step; the final-iteration value is the full product.
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_FAST_MUL_EN
          state_nxt = S_DONE;
`else
          state_nxt = is_mul ? S_MUL : S_DONE;
`endif
        end
      end
`ifndef ALU_FAST_MUL_EN
      S_MUL:  if (cnt == CNT_LAST) state_nxt = S_DONE;
`endif
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
`ifndef ALU_FAST_MUL_EN
      S_MUL:  busy = 1'b1;
`endif
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result / flag registers; hold until the next completion.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
`ifndef ALU_FAST_MUL_EN
    end else if (mul_last) begin
      result <= acc_nxt[WIDTH-1:0];
      zero   <= (acc_nxt[WIDTH-1:0] == '0);
      carry  <= 1'b0;
      ovf    <= |acc_nxt[2*WIDTH-1:WIDTH];
    end else if (accept && !is_mul) begin
`else
    end else if (accept) begin
`endif
      result <= rsp_c.res;
      zero   <= rsp_c.zero;
      carry  <= rsp_c.carry;
      ovf    <= rsp_c.ovf;
    end
  end

`ifndef ALU_FAST_MUL_EN
  // Multiplier state. Operands are captured at acceptance, so input changes
  // during the run are invisible to it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, op_a};
      mplier <= op_b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_MUL) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_multicycle.sv
// -----------------------------------------------------------------------------
// tb_alu_multicycle
//   Scoreboard bench for alu_multicycle. Each issued op pushes its expected
//   result/flags/latency; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_alu_multicycle;

  localparam int W = 32;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_LAT  = 33;
  localparam int MUL_BUSY = 32;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [5:0]   func;
  logic [4:0]   shift_amt;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, zero, carry, ovf;
  logic [W-1:0] result;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func),
    .shift_amt(shift_amt), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .zero(zero), .carry(carry), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z, c, o;
    int           lat, nbusy, t0;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(logic [W-1:0] r, logic c, logic o, bit is_mul);
    exp_t e;
    e.res = r; e.z = (r == '0); e.c = c; e.o = o;
    e.lat = is_mul ? MUL_LAT : 1;
    e.nbusy = is_mul ? MUL_BUSY : 0;
    e.t0 = 0;
    return e;
  endfunction

  // Reference model built on 64-bit integer arithmetic.
  function automatic exp_t model(logic [5:0] f, logic [4:0] sh, logic [W-1:0] a, logic [W-1:0] b);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    longint unsigned p;
    logic [W-1:0] r = '0;
    logic c = 1'b0, o = 1'b0;
    bit m = 0;
    case (f)
      6'd0: begin p = ua + ub; r = p[31:0]; c = p[32]; s = sa + sb;
                  o = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); end
      6'd1: begin r = a - b; c = (ua < ub); s = sa - sb;
                  o = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000); end
      6'd2: r = a & b;
      6'd3: begin p = ua * ub; r = p[31:0]; o = (p[63:32] != 0); m = 1; end
      6'd4: r = a | b;
      6'd5: r = a ^ b;
      6'd6: r = b << sh;
      6'd7: r = b >> sh;
      6'd8: begin r = b; for (int i = 0; i < int'(sh); i++) r = {r[W-1], r[W-1:1]}; end
      6'd9: r = (sa < sb) ? 1 : 0;
      default: r = '0;
    endcase
    return mk(r, c, o, m);
  endfunction

  // Monitor: sample on the falling edge, away from the active edge.
  int busy_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) busy_cnt = 0;
      else begin
        if (busy) busy_cnt++;
        if (done) begin
          chk("busy_with_done", busy, 0);
          if (exp_q.size() == 0) chk("spurious_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("result", result, e.res);
            chk("zero", zero, e.z);
            chk("carry", carry, e.c);
            chk("ovf", ovf, e.o);
            chk("latency", cyc - e.t0, e.lat);
            chk("busy_cycles", busy_cnt, e.nbusy);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    #1;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (exp_q.size() != 0) begin
      chk("timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic issue(input logic [5:0] f, input logic [4:0] sh,
                       input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    @(negedge clk);
    func = f; shift_amt = sh; op_a = a; op_b = b; start = 1'b1;
    e.t0 = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  initial begin
    exp_t e;
    int   n;
    rst_n = 1'b0; start = 1'b1; func = 6'd0; shift_amt = '0;
    op_a = 32'h1234; op_b = 32'h1;
    // Reset with start held high: reset wins.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_ovf", ovf, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", done | busy, 0);

    // Directed cases with hand-derived expectations.
    issue(6'd0, 5'd0, 32'h7FFFFFFF, 32'h1, mk(32'h80000000, 0, 1, 0));
    issue(6'd1, 5'd0, 32'd5, 32'd5, mk(32'h0, 0, 0, 0));
    issue(6'd1, 5'd0, 32'd3, 32'd5, mk(32'hFFFFFFFE, 1, 0, 0));
    issue(6'd6, 5'd31, 32'hDEAD, 32'h1, mk(32'h80000000, 0, 0, 0));
    issue(6'd8, 5'd4, 32'h0, 32'h80000000, mk(32'hF8000000, 0, 0, 0));
    issue(6'd9, 5'd0, 32'hFFFFFFFF, 32'h1, mk(32'h1, 0, 0, 0));
    issue(6'd3, 5'd0, 32'h00010000, 32'h00010000, mk(32'h0, 0, 1, 1));
    issue(6'd3, 5'd0, 32'd1234, 32'd5678, mk(32'd7006652, 0, 0, 1));
    issue(6'h2A, 5'd3, 32'hFFFF, 32'hFFFF, mk(32'h0, 0, 0, 0));

    // Randomised mix, including unknown codes.
    for (int i = 0; i < 30; i++) begin
      logic [5:0] f;
      logic [4:0] sh;
      logic [W-1:0] a, b;
      n  = $urandom_range(0, 11);
      f  = (n == 10) ? 6'h0A : (n == 11) ? 6'h3F : 6'(n);
      sh = 5'($urandom);
      a  = (i % 5 == 0) ? 32'h80000000 : $urandom;
      b  = (i % 7 == 0) ? 32'h7FFFFFFF : $urandom;
      issue(f, sh, a, b, model(f, sh, a, b));
    end

    // mul 7 x 9 with a start pulse and operand changes mid-run.
    @(negedge clk);
    func = 6'd3; op_a = 32'd7; op_b = 32'd9; start = 1'b1;
    e = mk(32'd63, 0, 0, 1); e.t0 = cyc; exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    func = 6'd0; op_a = 32'd1; op_b = 32'd2; start = 1'b1;
`ifdef ALU_FAST_MUL_EN
    e = model(6'd0, 5'd0, 32'd1, 32'd2); e.t0 = cyc; exp_q.push_back(e);
`endif
    @(negedge clk);
    start = 1'b0; op_a = 32'd100; op_b = 32'd3;
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    chk("mul_mid_done_seen", done, 1);
    // Start during the DONE cycle must be dropped.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_queued_ops", exp_q.size(), 0);

    // Abort a second mul at iteration 10 with reset.
    @(negedge clk);
    func = 6'd3; op_a = 32'hFFFF; op_b = 32'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    chk("abort_flags", {zero, carry, ovf}, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", busy | done, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
